// File: rtl/usb_tx_sched.sv
// rtl/usb_tx_sched.sv - UTMI transmit scheduler: handshake/data packet arbitration, CRC-16 append, inter-packet gap
// Handshake requests win arbitration in IDLE; data packets stream payload then complemented CRC-16/USB.
module usb_tx_sched #(
   parameter int IPG_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       hs_req,
   input  logic [3:0] hs_pid,
   output logic       hs_done,
   input  logic       dat_req,
   input  logic [3:0] dat_pid,
   input  logic       dat_zlp,
   input  logic [7:0] dat_data,
   input  logic       dat_valid,
   input  logic       dat_last,
   output logic       dat_ready,
   output logic       dat_done,
   output logic       dat_err,
   output logic       tx_valid,
   output logic [7:0] tx_data,
   input  logic       tx_ready,
   output logic       busy
);

   localparam int CW = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;

   typedef enum logic [2:0] {S_IDLE, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_GAP} state_t;

   state_t         state_q;
   logic [CW-1:0]  gap_cnt_q;
   logic [15:0]    crc_q;
   logic           is_hs_q;
   logic           zlp_q;
   logic           last_q;
   logic           tx_valid_q;
   logic [7:0]     tx_data_q;
   logic           hs_done_q;
   logic           dat_done_q;
   logic           dat_err_q;
   logic           busy_q;
   logic           accept;
   logic           need_byte;

   function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c ^ {8'h00, d};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
      end
      return r;
   endfunction

   assign accept    = tx_valid_q && tx_ready;
   // The next payload byte is wanted whenever the byte on the bus is taken and more payload is due.
   assign need_byte = accept && ((state_q == S_PID && !is_hs_q && !zlp_q) ||
                                 (state_q == S_DATA && !last_q));
   assign dat_ready = need_byte && dat_valid;

   assign hs_done  = hs_done_q;
   assign dat_done = dat_done_q;
   assign dat_err  = dat_err_q;
   assign tx_valid = tx_valid_q;
   assign tx_data  = tx_data_q;
   assign busy     = busy_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         gap_cnt_q  <= '0;
         crc_q      <= 16'hFFFF;
         is_hs_q    <= 1'b0;
         zlp_q      <= 1'b0;
         last_q     <= 1'b0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= 8'h00;
         hs_done_q  <= 1'b0;
         dat_done_q <= 1'b0;
         dat_err_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         hs_done_q  <= 1'b0;
         dat_done_q <= 1'b0;
         dat_err_q  <= 1'b0;
         if (need_byte) begin
            if (dat_valid) begin
               tx_data_q <= dat_data;
               last_q    <= dat_last;
               crc_q     <= crc16_upd(crc_q, dat_data);
               state_q   <= S_DATA;
            end else begin
               tx_valid_q <= 1'b0;
               tx_data_q  <= 8'h00;
               dat_err_q  <= 1'b1;
               gap_cnt_q  <= '0;
               state_q    <= S_GAP;
            end
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (hs_req) begin
                     is_hs_q    <= 1'b1;
                     tx_data_q  <= {~hs_pid, hs_pid};
                     tx_valid_q <= 1'b1;
                     busy_q     <= 1'b1;
                     state_q    <= S_PID;
                  end else if (dat_req) begin
                     is_hs_q    <= 1'b0;
                     zlp_q      <= dat_zlp;
                     crc_q      <= 16'hFFFF;
                     tx_data_q  <= {~dat_pid, dat_pid};
                     tx_valid_q <= 1'b1;
                     busy_q     <= 1'b1;
                     state_q    <= S_PID;
                  end
               end
               S_PID: begin
                  if (accept) begin
                     if (is_hs_q) begin
                        hs_done_q  <= 1'b1;
                        tx_valid_q <= 1'b0;
                        tx_data_q  <= 8'h00;
                        gap_cnt_q  <= '0;
                        state_q    <= S_GAP;
                     end else begin
                        tx_data_q <= ~crc_q[7:0];
                        state_q   <= S_CRC_LO;
                     end
                  end
               end
               S_DATA: begin
                  if (accept) begin
                     tx_data_q <= ~crc_q[7:0];
                     state_q   <= S_CRC_LO;
                  end
               end
               S_CRC_LO: begin
                  if (accept) begin
                     tx_data_q <= ~crc_q[15:8];
                     state_q   <= S_CRC_HI;
                  end
               end
               S_CRC_HI: begin
                  if (accept) begin
                     dat_done_q <= 1'b1;
                     tx_valid_q <= 1'b0;
                     tx_data_q  <= 8'h00;
                     gap_cnt_q  <= '0;
                     state_q    <= S_GAP;
                  end
               end
               S_GAP: begin
                  if (gap_cnt_q == CW'(IPG_CYCLES - 1)) begin
                     busy_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end else begin
                     gap_cnt_q <= gap_cnt_q + CW'(1);
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/usb_tx_sched.md
USB_TX_SCHED -- requirements
Module: usb_tx_sched

Interface
REQ-001 Parameter: IPG_CYCLES, default 8, number of idle clk cycles between the end of one packet and the start of the next.
REQ-002 clk  in  1  clock.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 hs_req  in  1  handshake packet request, level; held until hs_done.
REQ-005 hs_pid  in  4  handshake PID[3:0] (ACK/NAK/STALL/NYET), sampled at grant.
REQ-006 hs_done  out  1  one-cycle pulse when the handshake PID byte is accepted by the UTM.
REQ-007 dat_req  in  1  data packet request, level; held until dat_done or dat_err.
REQ-008 dat_pid  in  4  data PID[3:0] (DATA0/DATA1/DATA2/MDATA), sampled at grant.
REQ-009 dat_zlp  in  1  zero-length packet flag, sampled at grant.
REQ-010 dat_data  in  8  payload byte.
REQ-011 dat_valid  in  1  payload byte valid.
REQ-012 dat_last  in  1  marks the final payload byte; qualified by dat_valid.
REQ-013 dat_ready  out  1  payload byte consumed this cycle.
REQ-014 dat_done  out  1  one-cycle pulse when the last CRC byte is accepted.
REQ-015 dat_err  out  1  one-cycle pulse on payload underrun abort.
REQ-016 tx_valid  out  1  UTMI transmit valid.
REQ-017 tx_data  out  8  UTMI transmit byte.
REQ-018 tx_ready  in  1  UTMI byte accepted; the byte is accepted in any cycle where tx_valid && tx_ready.
REQ-019 busy  out  1  high whenever the state is not IDLE.

Function
REQ-020 States: IDLE, PID, DATA, CRC_LO, CRC_HI, GAP. All outputs are registered except dat_ready.
REQ-021 Arbitration happens only in IDLE.
- hs_req has priority over dat_req.
- Grant is never preempted.
- A request deasserted before grant is ignored.
REQ-022 Grant in cycle N: in cycle N+1 the state is PID, tx_valid=1, tx_data={~pid,pid}.
REQ-023 tx_data and tx_valid stay stable while tx_valid && !tx_ready, for any number of cycles.
REQ-024 PID accepted, handshake grant: hs_done pulses, state -> GAP, tx_valid=0 next cycle.
REQ-025 PID accepted, data grant with dat_zlp=1: state -> CRC_LO; dat_data is not consumed.
REQ-026 PID accepted, data grant with dat_zlp=0:
- If dat_valid=1: dat_ready=1 that cycle, tx_data<=dat_data, state -> DATA.
- If dat_valid=0: underrun (REQ-029).
REQ-027 In DATA, byte accepted:
- Current byte was flagged last: state -> CRC_LO.
- Otherwise, same load/underrun rule as REQ-026.
- The last flag is registered alongside the byte.
REQ-028 CRC: CRC-16/USB.
- Polynomial 0x8005 reflected (0xA001), LSB-first, init 0xFFFF.
- Updated on each payload byte as it is loaded into tx_data.
- Transmitted complemented: CRC_LO = ~crc[7:0], then CRC_HI = ~crc[15:8].
- CRC is reinitialised at every data grant.
- Accept in CRC_HI: dat_done pulses, state -> GAP.
REQ-029 Underrun: tx_valid=0 next cycle, dat_err pulses, state -> GAP. No CRC is sent, so the packet ends truncated and is discarded by the host.
REQ-030 dat_ready = tx_valid && tx_ready && dat_valid && state in {PID (data grant, non-ZLP), DATA (current byte not last)}. It is never asserted in other states.
REQ-031 GAP holds tx_valid=0 for exactly IPG_CYCLES cycles using a counter, then state -> IDLE. Arbitration resumes in the IDLE cycle.
REQ-032 Simultaneous hs_req and dat_req in IDLE: the handshake is sent first; data is granted on the next IDLE after its GAP.

Reset
REQ-033 rst asynchronously forces state IDLE and clears the gap counter and CRC.
REQ-034 Outputs during rst: tx_valid=0, tx_data=0x00, busy=0, hs_done=dat_done=dat_err=0, dat_ready=0.
REQ-035 Reset mid-packet aborts immediately with no done or err pulse. Operation resumes in the first cycle after rst deasserts.

Verification
REQ-036 ACK: hs_req with hs_pid=0x2, tx_ready=1 -> tx_data=0xD2 one cycle after grant, hs_done pulse, tx_valid low for 8 cycles, then busy=0.
REQ-037 DATA1 ZLP: dat_pid=0xB, dat_zlp=1 -> byte sequence 0x4B,0x00,0x00, dat_done on the third accept, dat_ready never asserted.
REQ-038 DATA0 payload 0x00,0x01,0x02,0x03, with tx_ready toggling 1/0 -> bytes 0xC3,0x00..0x03, then two CRC bytes equal to a golden CRC-16/USB model; data stays stable while tx_ready=0.
REQ-039 hs_req and dat_req asserted in the same IDLE cycle -> handshake packet, 8-cycle gap, then data packet.
REQ-040 Underrun: dat_valid=0 when the third payload byte is needed -> tx_valid=0 next cycle, dat_err pulse, no CRC bytes, GAP entered.
REQ-041 rst asserted while in DATA -> tx_valid=0 and busy=0 without waiting for a clock edge; a new ACK request after release transmits normally.
